// File: rtl/bcd_conv_scheduler.sv
// Shared iterative double-dabble binary-to-BCD converter with round-robin arbitration.
// One operand bit per clock; results are tagged with the granted requester id.
module bcd_conv_scheduler #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 4,
  localparam int unsigned IdW   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned AccW  = 4 * DIGITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
  output logic [N_REQ-1:0]         ack,
  output logic [AccW-1:0]          bcd_out,
  output logic                     bcd_valid,
  output logic [IdW-1:0]           bcd_id,
  output logic                     busy
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q;
  logic [IdW-1:0]    ptr_q;
  logic [IdW-1:0]    id_q;
  logic [WIDTH-1:0]  sreg_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;

  logic [WIDTH-1:0]  data_arr [N_REQ];
  logic              gnt_found;
  logic [IdW-1:0]    gnt_idx;
  logic [IdW-1:0]    ptr_next;
  logic [AccW-1:0]   acc_adj;
  logic [AccW-1:0]   acc_shift;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign data_arr[k] = data[k*WIDTH +: WIDTH];
  end

  // Search upward from the pointer, wrapping; sum is one bit wider so the wrap test cannot overflow.
  always_comb begin
    logic [IdW:0]   sum;
    logic [IdW-1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IdW+1)'(i);
      if (sum >= (IdW+1)'(N_REQ)) begin
        sum = sum - (IdW+1)'(N_REQ);
      end
      idx = sum[IdW-1:0];
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign ptr_next = (gnt_idx == IdW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Add-3 correction on every nibble >= 5, then shift in the next operand bit.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[AccW-2:0], sreg_q[WIDTH-1]};
  end

  assign busy = (state_q == StShift);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      id_q      <= '0;
      sreg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ack       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      bcd_id    <= '0;
    end else begin
      ack       <= '0;
      bcd_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt_found) begin
            sreg_q  <= data_arr[gnt_idx];
            acc_q   <= '0;
            cnt_q   <= CntW'(WIDTH - 1);
            id_q    <= gnt_idx;
            ack     <= N_REQ'(1) << gnt_idx;
            ptr_q   <= ptr_next;
            state_q <= StShift;
          end
        end
        StShift: begin
          acc_q  <= acc_shift;
          sreg_q <= sreg_q << 1;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            bcd_out   <= acc_shift;
            bcd_id    <= id_q;
            bcd_valid <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: cycle-level transaction model plus directed and random stimulus.
module tb_bcd_conv_scheduler;

  localparam int N = 3;
  localparam int W = 8;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]  ack;
  logic [4*D-1:0] bcd_out;
  logic          bcd_valid;
  logic [1:0]    bcd_id;
  logic          busy;

  int tests = 0;
  int fails = 0;

  bcd_conv_scheduler #(.N_REQ(N), .WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_id    (bcd_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0]  r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Transaction-level model: a conversion occupies W cycles after its grant edge.
  int          cyc = 0;
  bit          started = 0;
  bit          m_busy = 0;
  int          m_left = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  int          m_val = 0;
  logic [2:0]  e_ack = '0;
  logic        e_valid = 1'b0;
  logic [15:0] e_out = '0;
  logic [1:0]  e_id = '0;

  always @(posedge clk) begin
    int  k;
    bit  found;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_left = 0; m_ptr = 0;
      e_ack = '0; e_valid = 1'b0; e_out = '0; e_id = '0;
    end else begin
      e_ack = '0;
      e_valid = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          e_valid = 1'b1;
          e_out   = to_bcd(m_val);
          e_id    = 2'(m_id);
          m_busy  = 0;
        end
      end else if (req != 0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (!found && req[k]) begin
            found = 1;
            m_id  = k;
          end
        end
        m_val  = int'((data >> (m_id * W)) & 24'hFF);
        e_ack  = 3'(1 << m_id);
        m_ptr  = (m_id + 1) % N;
        m_busy = 1;
        m_left = W;
      end
    end
    started = 1;
  end

  // Logs of what the DUT produced, for the directed scenarios.
  logic [2:0]  ack_log[$];
  int          ack_cyc[$];
  logic [17:0] res_log[$];

  always @(negedge clk) begin
    if (started) begin
      chk("ack", 32'(ack), 32'(e_ack));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("bcd_valid", 32'(bcd_valid), 32'(e_valid));
      chk("bcd_out", 32'(bcd_out), 32'(e_out));
      chk("bcd_id", 32'(bcd_id), 32'(e_id));
      if (ack != 0) begin
        ack_log.push_back(ack);
        ack_cyc.push_back(cyc);
      end
      if (bcd_valid) res_log.push_back({bcd_id, bcd_out});
    end
  end

  task automatic wait_ack(input bit drop, output logic [2:0] a, output int n);
    a = '0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        a = ack;
        n = i;
        if (drop) req = req & ~ack;
        return;
      end
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        @(negedge clk);
        return;
      end
    end
    chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    ack_log.delete();
    ack_cyc.delete();
    res_log.delete();
  endtask

  function automatic logic [31:0] res_at(input int i);
    return (i < res_log.size()) ? 32'(res_log[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    return (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [2:0] a;
    int         n;
    int         k;

    // Model pinned against hand-computed values.
    chk("model_255", 32'(to_bcd(255)), 32'h0255);
    chk("model_99", 32'(to_bcd(99)), 32'h0099);

    // 1: reset held with all requests pending.
    req = 3'b111;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t1_rst_ack", 32'(ack), 32'd0);
      chk("t1_rst_out", 32'(bcd_out), 32'd0);
      chk("t1_rst_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    wait_ack(1'b1, a, n);
    chk("t1_first_ack", 32'(a), 32'b001);
    chk("t1_ack_delay", 32'(n), 32'd1);
    req = '0;
    drain();

    // 2: single conversion of 255 and its latency.
    data = '0;
    data[7:0] = 8'd255;
    req = 3'b001;
    wait_ack(1'b1, a, n);
    chk("t2_ack", 32'(a), 32'b001);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bcd_valid) begin
        n = i;
        break;
      end
    end
    chk("t2_latency", 32'(n), 32'd8);
    chk("t2_out", 32'(bcd_out), 32'h0255);
    chk("t2_id", 32'(bcd_id), 32'd0);
    @(negedge clk);
    chk("t2_busy_low", 32'(busy), 32'd0);
    chk("t2_valid_pulse", 32'(bcd_valid), 32'd0);
    chk("t2_out_hold", 32'(bcd_out), 32'h0255);

    // 3: three requesters, served in order.
    do_reset(2);
    data = {8'd200, 8'd99, 8'd0};
    req = 3'b111;
    repeat (3) wait_ack(1'b1, a, n);
    drain();
    chk("t3_ack0", ack_at(0), 32'b001);
    chk("t3_ack1", ack_at(1), 32'b010);
    chk("t3_ack2", ack_at(2), 32'b100);
    chk("t3_spacing", (ack_cyc.size() >= 2) ? 32'(ack_cyc[1] - ack_cyc[0]) : 32'hDEAD, 32'd9);
    chk("t3_res0", res_at(0), {14'd0, 2'd0, 16'h0000});
    chk("t3_res1", res_at(1), {14'd0, 2'd1, 16'h0099});
    chk("t3_res2", res_at(2), {14'd0, 2'd2, 16'h0200});

    // 4: requester 0 held forever, requester 2 joins mid-conversion.
    do_reset(1);
    data = {8'd42, 8'd0, 8'd17};
    req = 3'b001;
    wait_ack(1'b0, a, n);
    req = 3'b101;
    repeat (3) wait_ack(1'b0, a, n);
    req = '0;
    drain();
    chk("t4_g0", ack_at(0), 32'b001);
    chk("t4_g1", ack_at(1), 32'b100);
    chk("t4_g2", ack_at(2), 32'b001);
    chk("t4_g3", ack_at(3), 32'b100);

    // 5: reset on the fourth shift edge aborts the conversion.
    do_reset(1);
    data = '0;
    data[15:8] = 8'd128;
    req = 3'b010;
    wait_ack(1'b1, a, n);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_no_result", 32'(res_log.size()), 32'd0);
    chk("t5_out_zero", 32'(bcd_out), 32'd0);
    req = 3'b010;
    wait_ack(1'b1, a, n);
    drain();
    chk("t5_redo", res_at(0), {14'd0, 2'd1, 16'h0128});

    // 6: full sweep through requester 1.
    do_reset(1);
    for (int v = 0; v < 256; v++) begin
      data[15:8] = 8'(v);
      req = 3'b010;
      wait_ack(1'b1, a, n);
    end
    drain();
    chk("t6_count", 32'(res_log.size()), 32'd256);
    for (int v = 0; v < 256; v++) begin
      chk("t6_sweep", res_at(v), {14'd0, 2'd1, to_bcd(v)});
    end

    // Random traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      k = int'($urandom_range(0, 99));
      rst_n = (k != 0);
      if (k < 40) req = 3'($urandom_range(0, 7));
      data = 24'($urandom);
    end
    rst_n = 1'b1;
    req = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
